mac_sequencer: RTL and testbench
================================

// Module: mac_sequencer
// PURPOSE
//   Parametrised controller for a 2-D multiply-accumulate engine (transform/correlation over an N x N block).
//   For each output index (x,y) it clears the MAC, then sweeps every input index (u,v): it issues a memory read
//   at {u,v} and pulses active_MAC when the data returns. It then presents the result with a valid/ack handshake.
//   Sits between the block RAM (address/read_enable) and the MAC datapath (active_MAC/reset_MAC).
// PARAMETERS
//   IDX_W         3   bits per index; N = 2**IDX_W (3 -> 8x8 block, 64 inputs per output)
//   READ_LATENCY  1   cycles from read_enable high to RAM data valid; legal 1..7
// PORTS
//   clock         in   1         rising-edge clock
//   reset         in   1         asynchronous, active-high reset
//   start         in   1         begin a run; sampled only in IDLE
//   single        in   1         sampled with start: 1 = compute only (x_sel,y_sel); 0 = all N*N outputs
//   x_sel, y_sel  in   IDX_W     output index for single mode, captured with start
//   abort         in   1         terminate run; return to IDLE
//   result_ack    in   1         consumer accepted current result
//   u, v          out  IDX_W     current input index (to MAC coefficient lookup)
//   x, y          out  IDX_W     current output index
//   address       out  2*IDX_W   RAM read address = {u,v}
//   read_enable   out  1         RAM read strobe
//   active_MAC    out  1         MAC accumulates RAM data this cycle
//   reset_MAC     out  1         MAC accumulator clear
//   result_valid  out  1         MAC output holds final sum for (x,y)
//   ready         out  1         high in IDLE only
//   done          out  1         1-cycle pulse after last result accepted
// BEHAVIOUR
//   Reset: state=IDLE; u,v,x,y,address=0; read_enable,active_MAC,reset_MAC,result_valid,done=0; ready=1.
//   States: IDLE, CLEAR, ISSUE, WAIT, ACC, OUTPUT. All outputs are registered, decoded from next-state.
//   IDLE:   ready=1. start & !abort -> CLEAR; load x,y = single ? (x_sel,y_sel) : (0,0); u=v=0.
//   CLEAR:  reset_MAC=1 for exactly 1 cycle -> ISSUE.
//   ISSUE:  read_enable=1 for 1 cycle; address={u,v}. READ_LATENCY==1 -> ACC, else -> WAIT.
//   WAIT:   hold READ_LATENCY-1 cycles (down-counter) -> ACC. ACC is exactly READ_LATENCY cycles after ISSUE.
//   ACC:    active_MAC=1 for 1 cycle; advance (u,v) row-major (v fastest, v wraps N-1->0 with u+1).
//           (u,v) was last (N-1,N-1) -> OUTPUT and u,v wrap to 0; else -> ISSUE.
//   OUTPUT: result_valid=1, held until result_ack. result_ack may be high on the first OUTPUT cycle.
//           On ack: single, or (x,y)==(N-1,N-1) -> IDLE with done=1 for 1 cycle; else advance (x,y) row-major -> CLEAR.
//   Cost: per output 1 + N*N*(1+READ_LATENCY) cycles + ack wait. 8x8, L=1: 129 cycles + ack.
//   abort: in any non-IDLE state -> IDLE next cycle. All strobes and result_valid drop; done is not pulsed;
//          indices keep their values until the next start. abort beats result_ack in the same cycle.
//   start in non-IDLE states is ignored. start+abort together in IDLE: stay IDLE.
//   reset asserted mid-run: immediate return to reset values (asynchronous), no done.
//   Index arithmetic is modulo 2**IDX_W. Last-element detection uses all-ones compare, never a carry-out.
// STRUCTURE
//   Package mac_seq_pkg: state encoding localparams (one-hot, 6 bits), STATE_W.
//   Sub-module mac_index_counter #(IDX_W): 2-D row-major counter with clear, load, inc, last-flag outputs.
//     Instantiated twice: (u,v) and (x,y).
//   Top: FSM, latency down-counter, output registers.
// TESTING
//   1. IDX_W=2, L=1, single=0, ack tied high -> 16 result_valid pulses, x,y 0,0..3,3; done after 16*(1+16*2)+16 cycles.
//   2. IDX_W=3, L=3, single=1, x_sel=5, y_sel=2 -> 64 read_enable pulses at addresses 0..63;
//      each active_MAC exactly 3 cycles after its read_enable; one result with x=5,y=2; done.
//   3. Backpressure: hold result_ack low 10 cycles -> result_valid held, no read_enable/reset_MAC meanwhile;
//      ack -> reset_MAC next cycle.
//   4. abort during WAIT on output 3 -> next cycle IDLE, ready=1, read_enable=active_MAC=0, no done;
//      new start restarts at x=y=0.
//   5. start asserted mid-run and start+abort in IDLE -> no effect. reset pulse mid-ACC -> all outputs at reset values
//      while reset is high.
//   6. Scoreboard: a model MAC summing RAM[addr] per output matches the expected sums for a random RAM image, both L=1 and L=4.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared definitions for the MAC sequencer: one-hot state encoding
// and latency counter width.
package mac_seq_pkg;

    localparam int STATE_W = 6;

    localparam int I_IDLE   = 0;
    localparam int I_CLEAR  = 1;
    localparam int I_ISSUE  = 2;
    localparam int I_WAIT   = 3;
    localparam int I_ACC    = 4;
    localparam int I_OUTPUT = 5;

    localparam logic [STATE_W-1:0] S_IDLE   = 6'b000001;
    localparam logic [STATE_W-1:0] S_CLEAR  = 6'b000010;
    localparam logic [STATE_W-1:0] S_ISSUE  = 6'b000100;
    localparam logic [STATE_W-1:0] S_WAIT   = 6'b001000;
    localparam logic [STATE_W-1:0] S_ACC    = 6'b010000;
    localparam logic [STATE_W-1:0] S_OUTPUT = 6'b100000;

    // Wide enough for READ_LATENCY up to 7.
    localparam int LAT_W = 3;

endpackage

// File: rtl/mac_index_counter.sv
// Two-dimensional row-major index counter (b fastest) with clear,
// load and increment; last_o flags the all-ones corner.
module mac_index_counter #(
    parameter int IDX_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             inc_i,
    input  logic [IDX_W-1:0] a_load_i,
    input  logic [IDX_W-1:0] b_load_i,
    output logic [IDX_W-1:0] a_o,
    output logic [IDX_W-1:0] b_o,
    output logic             last_o
);

    logic [IDX_W-1:0] a_q, a_d;
    logic [IDX_W-1:0] b_q, b_d;

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (clr_i) begin
            a_d = '0;
            b_d = '0;
        end else if (load_i) begin
            a_d = a_load_i;
            b_d = b_load_i;
        end else if (inc_i) begin
            b_d = b_q + 1'b1;
            if (&b_q) a_d = a_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign a_o    = a_q;
    assign b_o    = b_q;
    assign last_o = (&a_q) & (&b_q);

endmodule

// File: rtl/mac_sequencer.sv
// Sequencer for an N x N multiply-accumulate engine: clears the MAC,
// sweeps all inputs through the RAM, then hands the sum to a consumer.
module mac_sequencer
    import mac_seq_pkg::*;
#(
    parameter int IDX_W        = 3,
    parameter int READ_LATENCY = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               single,
    input  logic [IDX_W-1:0]   x_sel,
    input  logic [IDX_W-1:0]   y_sel,
    input  logic               abort,
    input  logic               result_ack,
    output logic [IDX_W-1:0]   u,
    output logic [IDX_W-1:0]   v,
    output logic [IDX_W-1:0]   x,
    output logic [IDX_W-1:0]   y,
    output logic [2*IDX_W-1:0] address,
    output logic               read_enable,
    output logic               active_MAC,
    output logic               reset_MAC,
    output logic               result_valid,
    output logic               ready,
    output logic               done
);

    localparam logic [LAT_W-1:0] CNT_INIT =
        LAT_W'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);

    logic [STATE_W-1:0] state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic               single_q;
    logic               go, uv_last, xy_last, uv_inc, xy_inc;
    logic               re_d, act_d, rmac_d, rv_d, rdy_d, done_d;
    logic               re_q, act_q, rmac_q, rv_q, rdy_q, done_q;

    assign go     = state_q[I_IDLE] & start & ~abort;
    assign uv_inc = state_q[I_ACC] & ~abort;
    assign xy_inc = state_q[I_OUTPUT] & result_ack & ~abort
                  & ~single_q & ~xy_last;

    mac_index_counter #(.IDX_W(IDX_W)) u_uv (
        .clock    (clock),
        .reset    (reset),
        .clr_i    (go),
        .load_i   (1'b0),
        .inc_i    (uv_inc),
        .a_load_i ('0),
        .b_load_i ('0),
        .a_o      (u),
        .b_o      (v),
        .last_o   (uv_last)
    );

    mac_index_counter #(.IDX_W(IDX_W)) u_xy (
        .clock    (clock),
        .reset    (reset),
        .clr_i    (1'b0),
        .load_i   (go),
        .inc_i    (xy_inc),
        .a_load_i (single ? x_sel : '0),
        .b_load_i (single ? y_sel : '0),
        .a_o      (x),
        .b_o      (y),
        .last_o   (xy_last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            single_q <= 1'b0;
            re_q     <= 1'b0;
            act_q    <= 1'b0;
            rmac_q   <= 1'b0;
            rv_q     <= 1'b0;
            rdy_q    <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            if (go) single_q <= single;
            re_q     <= re_d;
            act_q    <= act_d;
            rmac_q   <= rmac_d;
            rv_q     <= rv_d;
            rdy_q    <= rdy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (1'b1)
            state_q[I_IDLE]:   if (go) state_d = S_CLEAR;
            state_q[I_CLEAR]:  state_d = S_ISSUE;
            state_q[I_ISSUE]: begin
                if (READ_LATENCY == 1) begin
                    state_d = S_ACC;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            state_q[I_WAIT]: begin
                if (cnt_q == '0) state_d = S_ACC;
                else             cnt_d   = cnt_q - 1'b1;
            end
            state_q[I_ACC]:    state_d = uv_last ? S_OUTPUT : S_ISSUE;
            state_q[I_OUTPUT]: begin
                if (result_ack)
                    state_d = (single_q | xy_last) ? S_IDLE : S_CLEAR;
            end
            default:           state_d = S_IDLE;
        endcase
        // Abort overrides everything, including a same-cycle ack.
        if (abort) state_d = S_IDLE;
    end

    always_comb begin
        re_d   = state_d[I_ISSUE];
        act_d  = state_d[I_ACC];
        rmac_d = state_d[I_CLEAR];
        rv_d   = state_d[I_OUTPUT];
        rdy_d  = state_d[I_IDLE];
        done_d = state_q[I_OUTPUT] & result_ack & ~abort
               & (single_q | xy_last);
    end

    assign address      = {u, v};
    assign read_enable  = re_q;
    assign active_MAC   = act_q;
    assign reset_MAC    = rmac_q;
    assign result_valid = rv_q;
    assign ready        = rdy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Randomised bench for mac_sequencer: three instances with different
// geometry/latency, a RAM/MAC model and per-scenario checks.
module tb_mac_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] start_v;
    logic       single, abort, result_ack;
    logic [2:0] x_sel, y_sel;

    logic [1:0] u0, v0, x0, y0;
    logic [3:0] a0;
    logic       re0, am0, rm0, rv0, rd0, dn0;
    logic [2:0] u1, v1, x1, y1;
    logic [5:0] a1;
    logic       re1, am1, rm1, rv1, rd1, dn1;
    logic [2:0] u2, v2, x2, y2;
    logic [5:0] a2;
    logic       re2, am2, rm2, rv2, rd2, dn2;

    always #5 clock = ~clock;

    mac_sequencer #(.IDX_W(2), .READ_LATENCY(1)) d0 (
        .clock(clock), .reset(reset), .start(start_v[0]),
        .single(single), .x_sel(x_sel[1:0]), .y_sel(y_sel[1:0]),
        .abort(abort), .result_ack(result_ack),
        .u(u0), .v(v0), .x(x0), .y(y0), .address(a0),
        .read_enable(re0), .active_MAC(am0), .reset_MAC(rm0),
        .result_valid(rv0), .ready(rd0), .done(dn0));

    mac_sequencer #(.IDX_W(3), .READ_LATENCY(3)) d1 (
        .clock(clock), .reset(reset), .start(start_v[1]),
        .single(single), .x_sel(x_sel), .y_sel(y_sel),
        .abort(abort), .result_ack(result_ack),
        .u(u1), .v(v1), .x(x1), .y(y1), .address(a1),
        .read_enable(re1), .active_MAC(am1), .reset_MAC(rm1),
        .result_valid(rv1), .ready(rd1), .done(dn1));

    mac_sequencer #(.IDX_W(3), .READ_LATENCY(4)) d2 (
        .clock(clock), .reset(reset), .start(start_v[2]),
        .single(single), .x_sel(x_sel), .y_sel(y_sel),
        .abort(abort), .result_ack(result_ack),
        .u(u2), .v(v2), .x(x2), .y(y2), .address(a2),
        .read_enable(re2), .active_MAC(am2), .reset_MAC(rm2),
        .result_valid(rv2), .ready(rd2), .done(dn2));

    int         sel = 0;
    int         N_sel = 4;
    int         L_sel = 1;
    logic [2:0] ou, ov, ox, oy;
    logic [5:0] oa;
    logic       ore, oam, orm, orv, ord, odn;

    always_comb begin
        case (sel)
            0: begin
                ou = {1'b0, u0}; ov = {1'b0, v0};
                ox = {1'b0, x0}; oy = {1'b0, y0};
                oa = {2'b0, a0};
                {ore, oam, orm, orv, ord, odn} = {re0, am0, rm0, rv0, rd0, dn0};
            end
            1: begin
                ou = u1; ov = v1; ox = x1; oy = y1; oa = a1;
                {ore, oam, orm, orv, ord, odn} = {re1, am1, rm1, rv1, rd1, dn1};
            end
            default: begin
                ou = u2; ov = v2; ox = x2; oy = y2; oa = a2;
                {ore, oam, orm, orv, ord, odn} = {re2, am2, rm2, rv2, rd2, dn2};
            end
        endcase
    end

    int checks = 0;
    int errors = 0;
    int ram [64];

    function automatic int coef(int xx, int yy, int uu, int vv);
        return 1 + ((xx * uu + yy * vv) % N_sel);
    endfunction

    function automatic int ref_sum(int xx, int yy);
        int s = 0;
        for (int uu = 0; uu < N_sel; uu++)
            for (int vv = 0; vv < N_sel; vv++)
                s += ram[uu * N_sel + vv] * coef(xx, yy, uu, vv);
        return s;
    endfunction

    // RAM + MAC model: every read returns ram[addr] L cycles later.
    int pend_t[$], pend_a[$], re_addr[$];
    int res_x[$], res_y[$], res_s[$];
    int lat_bad, n_act, n_rm, n_done, acc, cyc, mt, ma;
    logic rv_prev = 1'b0;

    always begin
        @(posedge clock);
        #1;
        cyc++;
        if (reset) begin
            rv_prev = 1'b0;
        end else begin
            if (ore) begin
                pend_t.push_back(cyc);
                pend_a.push_back(int'(oa));
                re_addr.push_back(int'(oa));
            end
            if (orm) begin
                acc = 0;
                n_rm++;
            end
            if (oam) begin
                n_act++;
                if (pend_t.size() == 0) begin
                    lat_bad++;
                end else begin
                    mt = pend_t.pop_front();
                    ma = pend_a.pop_front();
                    if (cyc - mt != L_sel || ma != int'(ou) * N_sel + int'(ov))
                        lat_bad++;
                    acc += ram[ma] * coef(int'(ox), int'(oy), ma / N_sel, ma % N_sel);
                end
            end
            if (orv && !rv_prev) begin
                res_x.push_back(int'(ox));
                res_y.push_back(int'(oy));
                res_s.push_back(acc);
            end
            rv_prev = orv;
            if (odn) n_done++;
        end
    end

    task automatic clr_logs();
        pend_t.delete(); pend_a.delete(); re_addr.delete();
        res_x.delete(); res_y.delete(); res_s.delete();
        lat_bad = 0; n_act = 0; n_rm = 0; n_done = 0; acc = 0;
    endtask

    task automatic use_dut(int k);
        @(negedge clock);
        sel   = k;
        N_sel = (k == 0) ? 4 : 8;
        L_sel = (k == 0) ? 1 : (k == 1) ? 3 : 4;
        for (int i = 0; i < 64; i++) ram[i] = int'($urandom_range(0, 255));
        clr_logs();
        @(negedge clock);
    endtask

    task automatic pulse_start(logic s, int xs, int ys);
        @(negedge clock);
        single     = s;
        x_sel      = 3'(xs);
        y_sel      = 3'(ys);
        start_v[sel] = 1'b1;
        @(negedge clock);
        start_v = '0;
    endtask

    task automatic wait_done(input int bound, output int k);
        k = 1;
        while (odn !== 1'b1 && k < bound) begin
            @(negedge clock);
            k++;
        end
    endtask

    task automatic do_abort();
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        clr_logs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start_v = '0; single = 0; abort = 0; result_ack = 0;
        x_sel = '0; y_sel = '0;
        repeat (3) @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #1;
            checks++;
            if ({ord, ore, oam, orm, orv, odn} !== 6'b100000) begin
                errors++;
                $display("FAIL reset_strobes dut%0d got %b want 100000", k,
                         {ord, ore, oam, orm, orv, odn});
            end
            checks++;
            if ({ou, ov, ox, oy, oa} !== 18'd0) begin
                errors++;
                $display("FAIL reset_index dut%0d got %h want 0", k,
                         {ou, ov, ox, oy, oa});
            end
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic check_results(string tag, int first, int cnt);
        checks++;
        if (res_x.size() != cnt) begin
            errors++;
            $display("FAIL %s_count got %0d want %0d", tag, res_x.size(), cnt);
        end
        for (int i = 0; i < res_x.size() && i < cnt; i++) begin
            int ex = (first + i) / N_sel;
            int ey = (first + i) % N_sel;
            checks++;
            if (res_x[i] != ex || res_y[i] != ey || res_s[i] != ref_sum(ex, ey)) begin
                errors++;
                $display("FAIL %s_res%0d got x%0d y%0d s%0d want x%0d y%0d s%0d",
                         tag, i, res_x[i], res_y[i], res_s[i], ex, ey, ref_sum(ex, ey));
            end
        end
    endtask

    task automatic test_full_run();
        int k;
        use_dut(0);
        result_ack = 1'b1;
        pulse_start(1'b0, 0, 0);
        wait_done(2000, k);
        checks++;
        if (k != 16 * (1 + 16 * 2) + 16 + 1) begin
            errors++;
            $display("FAIL full_done_cycle got %0d want %0d", k, 16 * 33 + 17);
        end
        check_results("full", 0, 16);
        checks++;
        if (lat_bad != 0 || n_act != 256 || n_rm != 16 || n_done != 1) begin
            errors++;
            $display("FAIL full_counts got lat%0d act%0d rm%0d dn%0d want 0 256 16 1",
                     lat_bad, n_act, n_rm, n_done);
        end
        result_ack = 1'b0;
    endtask

    task automatic test_single_l3();
        int k, bad;
        use_dut(1);
        result_ack = 1'b1;
        pulse_start(1'b1, 5, 2);
        wait_done(1000, k);
        checks++;
        if (k != 1 + 64 * 4 + 1 + 1) begin
            errors++;
            $display("FAIL single_done_cycle got %0d want 259", k);
        end
        bad = 0;
        for (int i = 0; i < re_addr.size(); i++) if (re_addr[i] != i) bad++;
        checks++;
        if (re_addr.size() != 64 || bad != 0) begin
            errors++;
            $display("FAIL single_addr got n%0d bad%0d want 64 0", re_addr.size(), bad);
        end
        checks++;
        if (lat_bad != 0 || n_act != 64 || n_done != 1) begin
            errors++;
            $display("FAIL single_lat got lat%0d act%0d dn%0d want 0 64 1",
                     lat_bad, n_act, n_done);
        end
        check_results("single", 5 * 8 + 2, 1);
        result_ack = 1'b0;
    endtask

    task automatic test_backpressure();
        int k;
        use_dut(0);
        result_ack = 1'b0;
        pulse_start(1'b0, 0, 0);
        k = 1;
        while (orv !== 1'b1 && k < 100) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (k != 34) begin
            errors++;
            $display("FAIL bp_first_valid got %0d want 34", k);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++;
            if ({orv, ore, orm} !== 3'b100) begin
                errors++;
                $display("FAIL bp_hold%0d got %b want 100", i, {orv, ore, orm});
            end
        end
        result_ack = 1'b1;
        @(negedge clock);
        result_ack = 1'b0;
        checks++;
        if ({orm, orv, ox, oy} !== {1'b1, 1'b0, 3'd0, 3'd1}) begin
            errors++;
            $display("FAIL bp_after_ack got %b want 10000001", {orm, orv, ox, oy});
        end
        do_abort();
    endtask

    task automatic test_abort_wait();
        int k;
        use_dut(1);
        result_ack = 1'b1;
        pulse_start(1'b0, 0, 0);
        k = 1;
        while (!(ox == 3'd0 && oy == 3'd2 && ore === 1'b1) && k < 1200) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (k != 2 * 258 + 2) begin
            errors++;
            $display("FAIL abort_reach got %0d want 518", k);
        end
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        checks++;
        if ({ord, ore, oam, orm, orv, odn} !== 6'b100000) begin
            errors++;
            $display("FAIL abort_idle got %b want 100000",
                     {ord, ore, oam, orm, orv, odn});
        end
        checks++;
        if ({ox, oy, ou, ov} !== {3'd0, 3'd2, 3'd0, 3'd0}) begin
            errors++;
            $display("FAIL abort_hold_idx got %h want 080", {ox, oy, ou, ov});
        end
        repeat (3) @(negedge clock);
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d want 0", n_done);
        end
        clr_logs();
        pulse_start(1'b0, 0, 0);
        checks++;
        if ({ox, oy, orm, ord} !== {3'd0, 3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL abort_restart got %b want 00000010", {ox, oy, orm, ord});
        end
        do_abort();
        result_ack = 1'b0;
    endtask

    task automatic test_ignore_and_reset();
        int k;
        use_dut(0);
        result_ack = 1'b1;
        pulse_start(1'b0, 0, 0);
        k = 1;
        repeat (4) begin @(negedge clock); k++; end
        single = 1'b1; x_sel = 3'd3; y_sel = 3'd3; start_v[0] = 1'b1;
        @(negedge clock);
        k++;
        start_v = '0; single = 1'b0;
        checks++;
        if ({ord, ox, oy} !== 7'd0) begin
            errors++;
            $display("FAIL midrun_start got %b want 0000000", {ord, ox, oy});
        end
        while (orv !== 1'b1 && k < 100) begin @(negedge clock); k++; end
        checks++;
        if (k != 34) begin
            errors++;
            $display("FAIL midrun_timing got %0d want 34", k);
        end
        k = 0;
        while (oam !== 1'b1 && k < 100) begin @(negedge clock); k++; end
        reset = 1'b1;
        #1;
        checks++;
        if ({ord, ore, oam, orm, orv, odn, ou, ov, ox, oy, oa} !== {6'b100000, 18'd0}) begin
            errors++;
            $display("FAIL reset_midacc got %h want %h",
                     {ord, ore, oam, orm, orv, odn, ou, ov, ox, oy, oa}, {6'b100000, 18'd0});
        end
        @(posedge clock);
        #1;
        checks++;
        if ({ord, ore, oam, orm, orv, odn, ou, ov, ox, oy, oa} !== {6'b100000, 18'd0}) begin
            errors++;
            $display("FAIL reset_held got %h want %h",
                     {ord, ore, oam, orm, orv, odn, ou, ov, ox, oy, oa}, {6'b100000, 18'd0});
        end
        @(negedge clock);
        reset = 1'b0;
        clr_logs();
        @(negedge clock);
        start_v[0] = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        start_v = '0;
        abort = 1'b0;
        @(negedge clock);
        checks++;
        if ({ord, orm, ore, n_done != 0} !== 4'b1000) begin
            errors++;
            $display("FAIL start_abort_idle got %b want 1000",
                     {ord, orm, ore, n_done != 0});
        end
        result_ack = 1'b0;
    endtask

    task automatic test_scoreboard(int k_dut, int bound);
        int k;
        use_dut(k_dut);
        pulse_start(1'b0, 0, 0);
        k = 1;
        while (odn !== 1'b1 && k < bound) begin
            result_ack = ($urandom_range(0, 2) == 0);
            @(negedge clock);
            k++;
        end
        result_ack = 1'b0;
        checks++;
        if (odn !== 1'b1) begin
            errors++;
            $display("FAIL sb%0d_timeout got %0d want <%0d", k_dut, k, bound);
        end
        check_results($sformatf("sb%0d", k_dut), 0, N_sel * N_sel);
        checks++;
        if (lat_bad != 0 || n_done != 1 || n_rm != N_sel * N_sel) begin
            errors++;
            $display("FAIL sb%0d_counts got lat%0d dn%0d rm%0d want 0 1 %0d",
                     k_dut, lat_bad, n_done, n_rm, N_sel * N_sel);
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_single_l3();
        test_backpressure();
        test_abort_wait();
        test_ignore_and_reset();
        test_scoreboard(0, 3000);
        test_scoreboard(2, 40000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
